// File: rtl/alu_op_sequencer.sv
// Valid/ready front-end for a 32-bit combinational ALU: registers the operands,
// waits a fixed settle time, then captures and hands off the ALU result.
module alu_op_sequencer #(
    parameter int W             = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [5:0]       alu_signal,
    input  logic [W-1:0]     alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;

    // Settle counter starts at SETTLE_CYCLES-1 so the result is sampled on the
    // SETTLE_CYCLES-th edge after the accepting edge.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state_r;
    logic [3:0] cnt_r;

    function automatic logic funct_supported(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    assign in_ready = (state_r == ST_IDLE) && reset;

    // Sequencer state, ALU input registers and result handoff registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            alu_a      <= {W{1'b0}};
            alu_b      <= {W{1'b0}};
            alu_signal <= 6'd0;
            out_data   <= {W{1'b0}};
            out_valid  <= 1'b0;
            out_err    <= 1'b0;
            op_count   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (funct_supported(in_funct)) begin
                            alu_a      <= in_a;
                            alu_b      <= in_b;
                            alu_signal <= in_funct;
                            cnt_r      <= CNT_INIT;
                            state_r    <= ST_WAIT;
                        end else begin
                            out_data  <= {W{1'b0}};
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            state_r   <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    // alu_result is only looked at on this single edge.
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        out_data  <= alu_result;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU model; a second
// instance with a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_alu_op_sequencer;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_funct;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [5:0]    alu_signal;
    logic [W-1:0]  alu_result;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_err;
    logic [15:0]   op_count;

    logic          in_ready4;
    logic [W-1:0]  alu_a4;
    logic [W-1:0]  alu_b4;
    logic [5:0]    alu_signal4;
    logic          out_valid4;
    logic [W-1:0]  out_data4;
    logic          out_err4;
    logic [3:0]    op_count4;

    int tests  = 0;
    int failed = 0;
    int exp_ops = 0;

    alu_op_sequencer #(.W(W), .SETTLE_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal),
        .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .op_count(op_count)
    );

    alu_op_sequencer #(.W(W), .SETTLE_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_signal(alu_signal4),
        .alu_result(alu_result), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_err(out_err4), .op_count(op_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU driven by the primary instance's registered inputs.
    always_comb begin
        case (alu_signal)
            6'd36:   alu_result = alu_a & alu_b;
            6'd37:   alu_result = alu_a | alu_b;
            6'd32:   alu_result = alu_a + alu_b;
            6'd34:   alu_result = alu_a - alu_b;
            6'd42:   alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full handshake with out_ready high; returns the captured result.
    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res);
        int n;
        in_valid = 1'b1; in_funct = f; in_a = a; in_b = b; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        chk("op_accept_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("op_result_timeout", {31'd0, out_valid}, 32'd1);
        res = out_data;
        step();
        exp_ops++;
    endtask

    initial begin
        logic [W-1:0] r;
        reset = 1'b0; in_valid = 1'b0; in_funct = 6'd0; in_a = '0; in_b = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD 5+7, out_ready high
        in_valid = 1'b1; in_funct = 6'd32; in_a = 32'd5; in_b = 32'd7; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("add_busy", {31'd0, in_ready}, 32'd0);
        step();
        chk("add_n1_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_data", out_data, 32'd12);
        chk("add_err", {31'd0, out_err}, 32'd0);
        step();
        exp_ops++;
        chk("add_ready", {31'd0, in_ready}, 32'd1);
        chk("add_count", {16'd0, op_count}, 32'd1);

        // SUB 3-5 with backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_funct = 6'd34; in_a = 32'd3; in_b = 32'd5;
        step();
        in_valid = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            chk("sub_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("sub_hold_data", out_data, 32'hFFFF_FFFE);
            chk("sub_hold_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        chk("sub_count_held", {16'd0, op_count}, 32'd1);
        out_ready = 1'b1;
        step();
        exp_ops++;
        chk("sub_released", {31'd0, out_valid}, 32'd0);
        chk("sub_idle", {31'd0, in_ready}, 32'd1);
        chk("sub_count", {16'd0, op_count}, 32'd2);

        // SLT then AND with in_valid held high
        in_valid = 1'b1; in_funct = 6'd42; in_a = 32'd3; in_b = 32'd5;
        step();
        in_funct = 6'd36; in_a = 32'hF0F0_F0F0; in_b = 32'hFF00_FF00;
        step(); step();
        chk("slt_data", out_data, 32'd1);
        chk("slt_alu_a_held", alu_a, 32'd3);
        step();
        exp_ops++;
        chk("and_wait_ready", {31'd0, in_ready}, 32'd1);
        chk("and_not_yet", alu_a, 32'd3);
        step();
        in_valid = 1'b0;
        chk("and_alu_a", alu_a, 32'hF0F0_F0F0);
        step(); step();
        chk("and_data", out_data, 32'hF000_F000);
        step();
        exp_ops++;
        chk("and_count", {16'd0, op_count}, 32'd4);

        // Unsupported funct
        in_valid = 1'b1; in_funct = 6'h3F; in_a = 32'd1; in_b = 32'd2;
        step();
        in_valid = 1'b0;
        chk("bad_valid", {31'd0, out_valid}, 32'd1);
        chk("bad_err", {31'd0, out_err}, 32'd1);
        chk("bad_data", out_data, 32'd0);
        chk("bad_signal", {26'd0, alu_signal}, 32'd36);
        chk("bad_alu_a", alu_a, 32'hF0F0_F0F0);
        step();
        exp_ops++;
        chk("bad_count", {16'd0, op_count}, 32'd5);

        // Reset mid-WAIT
        in_valid = 1'b1; in_funct = 6'd32; in_a = 32'd1; in_b = 32'd1;
        step();
        in_valid = 1'b0;
        reset = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        exp_ops = 0;
        #1;
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_signal", {26'd0, alu_signal}, 32'd0);
        chk("mid_rst_count", {16'd0, op_count}, 32'd0);
        step(); step(); step();
        chk("mid_rst_no_result", {31'd0, out_valid}, 32'd0);

        // Counter wrap: 17 ops on the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            do_op(6'd32, 32'(i), 32'(3 * i), r);
            chk("wrap_add_data", r, 32'(4 * i));
        end
        chk("wrap_count16", {16'd0, op_count}, 32'(exp_ops));
        chk("wrap_count4", {28'd0, op_count4}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Request/response front-end that drives the 32-bit combinational ALU.
- Accepts an operation (funct code plus two operands) over a valid/ready handshake.
- Drives the ALU's dataA/dataB/Signal inputs from registers and waits a fixed settle time for the ripple-carry result.
- Captures dataOut and presents it over an output valid/ready handshake. Unsupported codes are flagged without a result.

Parameters:
- W, 32, operand/result width; matches ALU datapath.
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before dataOut is sampled; legal range 1..15.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 at a clk edge resets)
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept a request
- in_funct  in  6  operation code: AND=36, OR=37, ADD=32, SUB=34, SLT=42
- in_a  in  W  operand A
- in_b  in  W  operand B
- alu_a  out  W  to ALU dataA
- alu_b  out  W  to ALU dataB
- alu_signal  out  6  to ALU Signal
- alu_result  in  W  from ALU dataOut
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  W  captured result
- out_err  out  1  request had an unsupported funct
- op_count  out  CNT_W  number of results handed off (including errored ones)

Behaviour:
- State machine: IDLE, WAIT, DONE. All state and outputs are registered except in_ready.
- in_ready:
  - in_ready = (state==IDLE) && reset==1.
  - Only one operation is in flight; a new request is not accepted while in WAIT or DONE.
- Reset (any cycle, including mid-operation): state=IDLE, alu_a=0, alu_b=0, alu_signal=0, out_data=0, out_valid=0, out_err=0, op_count=0, settle counter=0. Any in-flight operation is aborted silently.
- IDLE, in_valid==1 with supported funct (accept):
  - alu_a<=in_a, alu_b<=in_b, alu_signal<=in_funct.
  - cnt<=SETTLE_CYCLES-1; go to WAIT.
- IDLE, in_valid==1 with unsupported funct (accept):
  - ALU outputs unchanged; out_data<=0, out_err<=1, out_valid<=1; go to DONE.
- WAIT:
  - ALU outputs held constant.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: out_data<=alu_result, out_err<=0, out_valid<=1; go to DONE.
- DONE:
  - out_valid, out_data and out_err held stable until out_ready==1.
  - On out_valid&&out_ready: out_valid<=0, op_count<=op_count+1 (wraps modulo 2^CNT_W), go to IDLE.
  - A new request may be accepted in the following cycle, not in the same cycle.
- Latency, counted in edges after the accepting edge:
  - Supported op: out_valid rises SETTLE_CYCLES edges after accept.
  - Unsupported op: out_valid rises 1 edge after accept.
- out_ready held high permanently: one op completes every SETTLE_CYCLES+2 cycles.
- in_valid while not in IDLE: ignored. The requester must hold in_valid and operands until in_ready.
- alu_a/alu_b/alu_signal keep the last issued values after completion; they change only on the next supported accept or on reset.
- out_ready asserted while out_valid==0: no effect.
- Results are passed through bit-exact; the sequencer performs no arithmetic on operands.
- Unknown/X on alu_result outside WAIT's sampling edge must not propagate.

Test Plan:
- The bench models the ALU behaviourally, driving alu_result from alu_a/alu_b/alu_signal.
- Reset: hold reset=0 for 3 edges mid-WAIT, then release -> all outputs 0, in_ready=1 on the first cycle after release, op_count=0.
- ADD, SETTLE_CYCLES=2: in_funct=32, a=5, b=7 accepted at edge N, out_ready=1 -> out_valid=1, out_data=12, out_err=0 after edge N+2; in_ready=1 after edge N+3; op_count=1.
- SUB with backpressure: funct=34, a=3, b=5, out_ready=0 for 4 cycles -> out_data=0xFFFFFFFE held stable, in_ready=0 throughout; out_ready pulse -> IDLE, op_count increments once.
- SLT then AND back-to-back, in_valid held high: funct=42, a=3, b=5 -> out_data=1; funct=36, a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000. The second request is accepted only once in_ready returns.
- Unsupported funct=0x3F -> out_valid one edge after accept, out_err=1, out_data=0, alu_signal unchanged.
- Counter wrap with CNT_W=4: 17 completed ops -> op_count=1.
